// File: rtl/sm3_pkg.sv
// sm3_pkg: shared SM3 constants, FSM encodings and word helpers
// Contents: word_t, WORD_WIDTH, ROUNDS, T_LOW/T_HIGH, SM3_IV[0:7], SM3_IV_VEC,
//           ST_IDLE/ST_ROUND/ST_FINAL, rotl32(x, n), p0(x)
package sm3_pkg;
   localparam int WORD_WIDTH = 32;
   localparam int ROUNDS     = 64;
   typedef logic [WORD_WIDTH-1:0] word_t;
   localparam word_t T_LOW  = 32'h79CC4519;
   localparam word_t T_HIGH = 32'h7A879D8A;
   localparam word_t SM3_IV [0:7] = '{
      32'h7380166F, 32'h4914B2B9, 32'h172442D7, 32'hDA8A0600,
      32'hA96F30BC, 32'h163138AA, 32'hE38DEE4D, 32'hB0FB0E4E
   };
   localparam logic [255:0] SM3_IV_VEC = {SM3_IV[0], SM3_IV[1], SM3_IV[2], SM3_IV[3],
                                          SM3_IV[4], SM3_IV[5], SM3_IV[6], SM3_IV[7]};
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;
   // rotate via a doubled word so n = 0 needs no special case
   function automatic word_t rotl32(input word_t x, input logic [4:0] n);
      logic [63:0] t;
      t = {x, x} << n;
      return t[63:32];
   endfunction
   function automatic word_t p0(input word_t x);
      return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
   endfunction
endpackage

// File: rtl/sm3_round.sv
// sm3_round: one combinational SM3 compression round
// Ports: st_in  - A..H before the round ([255:224] = A ... [31:0] = H)
//        w      - W_j
//        w_p    - W'_j
//        j      - round index 0..63
//        st_out - A..H after the round
module sm3_round import sm3_pkg::*; (
   input  logic [255:0] st_in,
   input  logic [31:0]  w,
   input  logic [31:0]  w_p,
   input  logic [5:0]   j,
   output logic [255:0] st_out
);
   word_t a, b, c, d, e, f, g, h, a12, tj, ss1, ss2, ff, gg, tt1, tt2;
   logic hi;
   always_comb begin
      {a, b, c, d, e, f, g, h} = st_in;
      hi     = j[5] | j[4];
      // T_j <<< (j mod 32): the rotate amount is simply the low five bits of j
      tj     = rotl32(hi ? T_HIGH : T_LOW, j[4:0]);
      a12    = rotl32(a, 5'd12);
      ss1    = rotl32(a12 + e + tj, 5'd7);
      ss2    = ss1 ^ a12;
      ff     = hi ? ((a & b) | (a & c) | (b & c)) : (a ^ b ^ c);
      gg     = hi ? ((e & f) | (~e & g)) : (e ^ f ^ g);
      tt1    = ff + d + ss2 + w_p;
      tt2    = gg + h + ss1 + w;
      st_out = {tt1, a, rotl32(b, 5'd9), c, p0(tt2), e, rotl32(f, 5'd19), g};
   end
endmodule

// File: rtl/sm3_compress.sv
// sm3_compress: SM3 compression, one round per accepted {W_j, W'_j} pair, block chaining
// Ports: clk, rst_n (async, active-low)
//        w_valid/w_data/w_first - expanded word pairs, w_data = {W_j, W'_j}, no backpressure
//        msg_new/msg_last       - sampled with the w_first pair: reload IV / final block flag
//        busy                   - a block is in progress (round counter != 0 or FINAL)
//        digest                 - chaining value V as of the last update
//        digest_valid/final     - one-cycle pulse on chaining update / block was last of message
//        proto_err              - one-cycle pulse on protocol violation
module sm3_compress import sm3_pkg::*; (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         w_valid,
   input  logic [63:0]  w_data,
   input  logic         w_first,
   input  logic         msg_new,
   input  logic         msg_last,
   output logic         busy,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         digest_final,
   output logic         proto_err
);
   logic [1:0]   state;
   logic [5:0]   j, rnd_j;
   logic [255:0] st, v, rnd_in, rnd_out;
   logic         last_r, start;

   // a w_first pair starts round 0 from IDLE, or abandons a block in progress
   assign start  = w_valid & w_first & (state != ST_FINAL);
   assign rnd_j  = start ? 6'd0 : j;
   assign rnd_in = !start ? st : (msg_new ? SM3_IV_VEC : v);
   assign busy   = (j != 6'd0) | (state == ST_FINAL);

   sm3_round u_round (
      .st_in  (rnd_in),
      .w      (w_data[63:32]),
      .w_p    (w_data[31:0]),
      .j      (rnd_j),
      .st_out (rnd_out)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= ST_IDLE;
         j            <= 6'd0;
         st           <= '0;
         v            <= SM3_IV_VEC;
         last_r       <= 1'b0;
         digest       <= '0;
         digest_valid <= 1'b0;
         digest_final <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         digest_valid <= 1'b0;
         digest_final <= 1'b0;
         proto_err    <= 1'b0;
         if (state == ST_FINAL) begin
            v            <= st ^ v;
            digest       <= st ^ v;
            digest_valid <= 1'b1;
            digest_final <= last_r;
            proto_err    <= w_valid;
            state        <= ST_IDLE;
         end else if (start) begin
            st        <= rnd_out;
            j         <= 6'd1;
            last_r    <= msg_last;
            state     <= ST_ROUND;
            proto_err <= (state == ST_ROUND);
            if (msg_new) begin
               v      <= SM3_IV_VEC;
               digest <= SM3_IV_VEC;
            end
         end else if (w_valid) begin
            if (state == ST_ROUND) begin
               st <= rnd_out;
               j  <= j + 6'd1;
               if (j == 6'(ROUNDS - 1)) begin
                  state <= ST_FINAL;
                  j     <= 6'd0;
               end
            end else
               proto_err <= 1'b1;
         end
      end
endmodule

// File: tb/tb_sm3_compress.sv
// tb_sm3_compress: scoreboard bench for sm3_compress using SM3 reference vectors
module tb_sm3_compress;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic         w_valid = 1'b0, w_first = 1'b0, msg_new = 1'b0, msg_last = 1'b0;
   logic [63:0]  w_data = '0;
   logic         busy, digest_valid, digest_final, proto_err;
   logic [255:0] digest;

   localparam logic [255:0] ABC_D  = 256'h66C7F0F4_62EEEDD9_D1F2D46B_DC10E4E2_4167C487_5CF2F7A2_297DA02B_8F4BA8E0;
   localparam logic [255:0] ABCD_D = 256'hDEBE9FF9_2275B8A1_38604889_C18E5A4D_6FDB70E5_387E5765_293DCBA3_9C0C5732;

   typedef struct {bit chk; logic [255:0] d; logic f;} exp_t;
   exp_t sbq[$];
   exp_t mon_e;
   int n_tests = 0, n_fail = 0, n_perr = 0, p_base;
   logic [511:0] abc_blk, abcd_b0, abcd_b1;

   sm3_compress dut (
      .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_data(w_data), .w_first(w_first),
      .msg_new(msg_new), .msg_last(msg_last), .busy(busy), .digest(digest),
      .digest_valid(digest_valid), .digest_final(digest_final), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (proto_err === 1'b1) n_perr++;
      if (digest_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_digest_valid: got digest %h, expected no pulse", digest);
         end else begin
            mon_e = sbq.pop_front();
            check("digest_final", {255'b0, digest_final}, {255'b0, mon_e.f});
            if (mon_e.chk) check("digest", digest, mon_e.d);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      w_valid = 1'b0;
      w_first = 1'b0;
      repeat (n) cyc();
   endtask

   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] p1(input logic [31:0] x);
      return x ^ rl(x, 15) ^ rl(x, 23);
   endfunction

   // expands the padded block and feeds the first npairs pairs; a full block
   // registers its expected result just before the last pair goes out
   task automatic send_block(input logic [511:0] blk, input bit mnew, input bit mlast, input bit gaps,
                             input int npairs, input bit chk, input logic [255:0] dexp);
      logic [31:0] wv [0:67];
      exp_t e;
      for (int i = 0; i < 16; i++) wv[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 68; i++)
         wv[i] = p1(wv[i-16] ^ wv[i-9] ^ rl(wv[i-3], 15)) ^ rl(wv[i-13], 7) ^ wv[i-6];
      for (int k = 0; k < npairs; k++) begin
         if (gaps && k > 0)
            repeat ($urandom_range(1, 5)) begin
               w_valid = 1'b0;
               check("busy_in_gap", {255'b0, busy}, 256'd1);
               cyc();
            end
         if (k == 63) begin
            e.chk = chk;
            e.d   = dexp;
            e.f   = mlast;
            sbq.push_back(e);
         end
         w_valid  = 1'b1;
         w_first  = (k == 0);
         msg_new  = mnew;
         msg_last = mlast;
         w_data   = {wv[k], wv[k] ^ wv[k+4]};
         cyc();
      end
      w_valid = 1'b0;
      w_first = 1'b0;
   endtask

   initial begin
      abc_blk          = '0;
      abc_blk[511:480] = 32'h61626380;
      abc_blk[31:0]    = 32'h18;
      abcd_b0          = {16{32'h61626364}};
      abcd_b1          = '0;
      abcd_b1[511:480] = 32'h80000000;
      abcd_b1[31:0]    = 32'h200;

      repeat (2) cyc();
      check("reset_digest", digest, '0);
      check("reset_busy", {255'b0, busy}, '0);
      check("reset_digest_valid", {255'b0, digest_valid}, '0);
      check("reset_proto_err", {255'b0, proto_err}, '0);
      rst_n = 1'b1;
      cyc();

      // single-block "abc"
      send_block(abc_blk, 1'b1, 1'b1, 1'b0, 64, 1'b1, ABC_D);
      idle(3);
      check("busy_after_block", {255'b0, busy}, '0);

      // two-block "abcd"x16 at minimum block spacing
      send_block(abcd_b0, 1'b1, 1'b0, 1'b0, 64, 1'b0, '0);
      idle(1);
      send_block(abcd_b1, 1'b0, 1'b1, 1'b0, 64, 1'b1, ABCD_D);
      idle(3);

      // new message reloads IV
      send_block(abc_blk, 1'b1, 1'b1, 1'b0, 64, 1'b1, ABC_D);
      idle(3);

      // stalls between pairs
      send_block(abc_blk, 1'b1, 1'b1, 1'b1, 64, 1'b1, ABC_D);
      idle(3);

      // protocol violations: stray word in IDLE, restart mid-block, word in FINAL
      p_base  = n_perr;
      w_valid = 1'b1;
      w_first = 1'b0;
      w_data  = 64'h0123456789ABCDEF;
      cyc();
      idle(2);
      check("perr_idle_count", 256'(n_perr), 256'(p_base + 1));
      send_block(abc_blk, 1'b1, 1'b1, 1'b0, 30, 1'b0, '0);
      send_block(abc_blk, 1'b1, 1'b1, 1'b0, 64, 1'b1, ABC_D);
      w_valid = 1'b1;
      w_first = 1'b0;
      w_data  = 64'hDEADBEEFCAFEF00D;
      cyc();
      idle(3);
      check("perr_total_count", 256'(n_perr), 256'(p_base + 3));
      check("digest_held", digest, ABC_D);

      // asynchronous reset mid-block
      send_block(abc_blk, 1'b1, 1'b1, 1'b0, 40, 1'b0, '0);
      check("busy_mid_block", {255'b0, busy}, 256'd1);
      rst_n = 1'b0;
      #1;
      check("rst_digest", digest, '0);
      check("rst_busy", {255'b0, busy}, '0);
      check("rst_digest_valid", {255'b0, digest_valid}, '0);
      cyc();
      rst_n = 1'b1;
      cyc();
      send_block(abc_blk, 1'b1, 1'b1, 1'b0, 64, 1'b1, ABC_D);

      for (int k = 0; k < 20 && sbq.size() != 0; k++) cyc();
      idle(3);
      check("pending_digests", 256'(sbq.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sm3_compress.md
Name: sm3_compress

Overview:
- Downstream consumer of the SM3 message-expansion stage.
- Accepts 64 consecutive {W_j, W'_j} pairs per 512-bit block and runs one SM3 compression round per accepted pair.
- After round 63, applies the chaining XOR (V_{i+1} = ABCDEFGH ^ V_i) and presents the 256-bit chaining value / digest.
- Chains multiple blocks of one message; reloads the standard IV at the start of each new message.

Parameters:
- WORD_WIDTH, 32, SM3 word width; fixed by algorithm, not intended for override.
- ROUNDS, 64, rounds per block; fixed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- w_valid  in  1  w_data valid this cycle; no backpressure
- w_data  in  64  [63:32] = W_j, [31:0] = W'_j
- w_first  in  1  qualified by w_valid; marks the j=0 pair of a block
- msg_new  in  1  sampled with w_valid&w_first; 1 = block is first of message, V_i := IV
- msg_last  in  1  sampled with w_valid&w_first; 1 = block is last of message
- busy  out  1  1 while round counter != 0 or in FINAL
- digest  out  256  chaining value V; [255:224] = A ... [31:0] = H
- digest_valid  out  1  one-cycle pulse when digest is updated
- digest_final  out  1  qualified by digest_valid; block was flagged msg_last
- proto_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (async):
  - All outputs 0; state IDLE; round counter j = 0; A..H = 0.
  - V register = IV: 7380166F 4914B2B9 172442D7 DA8A0600 A96F30BC 163138AA E38DEE4D B0FB0E4E.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - w_valid&w_first → perform round 0 at this edge.
  - If msg_new, round-0 inputs A..H come from IV and the V register also loads IV; else they come from V.
  - Latch msg_last. Go to ROUND with j = 1.
  - w_valid without w_first → ignored, proto_err pulse.
- ROUND:
  - Each w_valid cycle executes round j and increments j. A w_valid gap stalls the round with all state held.
  - Round j == 63 accepted → FINAL, j = 0.
  - w_valid&w_first in ROUND → proto_err pulse. Current block is abandoned and the new block restarts at round 0 with the IDLE loading rules; V is unchanged by the abandoned block.
- FINAL (exactly 1 cycle):
  - V <= {A..H} ^ V; digest_valid = 1; digest_final = latched msg_last.
  - digest reflects the new V on the same edge.
  - Go to IDLE.
  - Any w_valid in FINAL → dropped, proto_err pulse.
- Latency: word 63 accepted at edge E → digest/digest_valid registered at edge E+1.
- Minimum block period is 65 cycles. The next w_first is legal from the cycle after FINAL.
- Round function, all arithmetic mod 2^32, <<< = rotate left:
  - T_j = 79CC4519 for j<16, 7A879D8A for j≥16.
  - SS1 = ((A<<<12) + E + (T_j <<< (j mod 32))) <<< 7
  - SS2 = SS1 ^ (A<<<12)
  - FF: X^Y^Z for j<16; (X&Y)|(X&Z)|(Y&Z) for j≥16.
  - GG: X^Y^Z for j<16; (X&Y)|(~X&Z) for j≥16.
  - TT1 = FF(A,B,C) + D + SS2 + W'_j
  - TT2 = GG(E,F,G) + H + SS1 + W_j
  - Updates: D=C, C=B<<<9, B=A, A=TT1, H=G, G=F<<<19, F=E, E=P0(TT2).
  - P0(X) = X ^ (X<<<9) ^ (X<<<17).
- T_j <<< j: use a rotating 32-bit register, reloaded at round 0 and rotated 1 per round (swap constant at j=16), or a combinational rotate. Either is acceptable; the result must be identical.
- Reset mid-block: everything returns to reset state; a partial digest is never emitted.
- digest holds its value between pulses. It is also updated when msg_new is accepted (V := IV is visible on digest, without a digest_valid pulse).

Decomposition:
- Shared package sm3_pkg holds:
  - SM3_IV[0:7], T_LOW = 79CC4519, T_HIGH = 7A879D8A
  - WORD_WIDTH, ROUNDS
  - functions rotl32 and p0
- One sub-module, sm3_round: combinational single round taking (A..H, W_j, W'_j, j) and producing the next A..H. It is reusable by the FINAL/verification model.

Test Plan:
1. "abc" single block (msg_new=1, msg_last=1), 64 back-to-back pairs from the bench expansion model → digest_valid one cycle after pair 63 with digest = 66C7F0F4 62EEEDD9 D1F2D46B DC10E4E2 4167C487 5CF2F7A2 297DA02B 8F4BA8E0, digest_final=1.
2. "abcd"×16 two blocks (block 0: msg_new=1, msg_last=0; block 1: msg_new=0, msg_last=1) → first pulse digest_final=0; second pulse digest = DEBE9FF9 2275B8A1 38604889 C18E5A4D 6FDB70E5 387E5765 293DCBA3 9C0C5732.
3. "abc" with random 1–5 cycle w_valid gaps → identical digest to scenario 1; busy stays 1 throughout the gaps.
4. Second message with msg_new=1 after scenario 2 → "abc" digest again (IV reload verified).
5. w_first injected at pair 30, then a clean "abc" block follows → proto_err one pulse; digest equals "abc"; w_valid in the FINAL cycle → proto_err, digest unaffected.
6. rst_n asserted at pair 40 → digest=0, busy=0, digest_valid=0 immediately; a subsequent "abc" block yields the correct digest.
